// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Sequential packed-BCD to binary converter that uses reverse
//               double-dabble and a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WID    = 14
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    start_in,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic                    busy_out,
    output logic                    done_out,
    output logic [BIN_WID-1:0]      bin_out,
    output logic                    err_out,
    output logic                    ovf_out
);

    localparam int C_BCD_WID = 4 * NUM_DIGITS;
    localparam int C_CNT_WID = $clog2(BIN_WID + 1);
    localparam logic [C_CNT_WID-1:0] C_LAST_CNT = C_CNT_WID'(BIN_WID - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [C_BCD_WID-1:0]         r_bcd;
    logic [BIN_WID-1:0]           r_bin;
    logic [C_CNT_WID-1:0]         r_cnt;
    logic                         r_err;
    logic                         w_bad;
    logic [C_BCD_WID+BIN_WID-1:0] w_sh;
    logic [C_BCD_WID-1:0]         w_bcd_corr;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // Shift first, then correct each digit independently (no inter-digit borrow).
    always_comb begin
        w_sh       = {r_bcd, r_bin} >> 1;
        w_bcd_corr = w_sh[C_BCD_WID+BIN_WID-1:BIN_WID];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sh[BIN_WID+4*i +: 4] >= 4'd8) begin
                w_bcd_corr[4*i +: 4] = w_sh[BIN_WID+4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_next = w_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == C_LAST_CNT) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd    <= '0;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            done_out <= 1'b0;
            bin_out  <= '0;
            err_out  <= 1'b0;
            ovf_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_bcd <= bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        r_err <= w_bad;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_corr;
                    r_bin <= w_sh[BIN_WID-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    done_out <= 1'b1;
                    bin_out  <= r_err ? '0 : r_bin;
                    err_out  <= r_err;
                    // Leftover BCD after the last shift means the value exceeded BIN_WID bits.
                    ovf_out  <= ~r_err & (|r_bcd);
                end
                default: ;
            endcase
        end
    end

    assign busy_out = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_bin_seq
// Description : Self-checking bench for bcd_to_bin_seq (default and 3-digit/8-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b;
    logic        busy_a, done_a, err_a, ovf_a;
    logic        busy_b, done_b, err_b, ovf_b;
    logic [13:0] bin_a;
    logic [7:0]  bin_b;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_bin_seq dut_a (
        .clk_in(clk), .rst_n(rst_n), .start_in(start_a), .bcd_in(bcd_a),
        .busy_out(busy_a), .done_out(done_a), .bin_out(bin_a),
        .err_out(err_a), .ovf_out(ovf_a)
    );

    bcd_to_bin_seq #(.NUM_DIGITS(3), .BIN_WID(8)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .start_in(start_b), .bcd_in(bcd_b),
        .busy_out(busy_b), .done_out(done_b), .bin_out(bin_b),
        .err_out(err_b), .ovf_out(ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: decimal value from the digits, then plain modular arithmetic.
    function automatic void ref_model(input logic [15:0] bcd, input int nd, input int w,
                                      output int bin, output bit err, output bit ovf);
        int v;
        int d;
        v   = 0;
        err = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) err = 1'b1;
            v = v * 10 + d;
        end
        bin = err ? 0 : (v % (1 << w));
        ovf = !err && (v >= (1 << w));
    endfunction

    function automatic logic [15:0] rand_valid(input int nd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Issues one start pulse (caller is at #1 after a rising edge, DUT idle) and waits for done.
    task automatic run_conv(input bit sel, input logic [15:0] bcd, output int lat,
                            output int busy_cnt, output int bin, output logic err,
                            output logic ovf, output bit timeout);
        if (!sel) begin start_a = 1'b1; bcd_a = bcd; end
        else      begin start_b = 1'b1; bcd_b = bcd[11:0]; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        busy_cnt = (sel ? busy_b : busy_a) ? 1 : 0;
        lat = 0; timeout = 1'b1; bin = 0; err = 1'b0; ovf = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (sel ? busy_b : busy_a) busy_cnt++;
            if (sel ? done_b : done_a) begin
                lat = n; timeout = 1'b0;
                bin = sel ? int'(bin_b) : int'(bin_a);
                err = sel ? err_b : err_a;
                ovf = sel ? ovf_b : ovf_a;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bcd_a = '0; bcd_b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a, done_a, bin_a, err_a, ovf_a} !== '0) begin
            n_bad++; $display("FAIL reset_a: got %b required 0", {busy_a, done_a, bin_a, err_a, ovf_a});
        end
        n_cmp++;
        if ({busy_b, done_b, bin_b, err_b, ovf_b} !== '0) begin
            n_bad++; $display("FAIL reset_b: got %b required 0", {busy_b, done_b, bin_b, err_b, ovf_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic check_conv(input string nm, input bit sel, input logic [15:0] bcd);
        int lat, bc, bin, eb, nd, w;
        logic err, ovf;
        bit to, e_err, e_ovf;
        nd = sel ? 3 : 4;
        w  = sel ? 8 : 14;
        ref_model(bcd, nd, w, eb, e_err, e_ovf);
        run_conv(sel, bcd, lat, bc, bin, err, ovf, to);
        n_cmp++;
        if (to) begin
            n_bad++; $display("FAIL %s timeout bcd=%h: no done within 40 cycles", nm, bcd);
            return;
        end
        n_cmp++;
        if (lat !== (e_err ? 1 : w + 1)) begin
            n_bad++; $display("FAIL %s latency bcd=%h: got %0d required %0d", nm, bcd, lat, e_err ? 1 : w + 1);
        end
        n_cmp++;
        if (bc !== (e_err ? 0 : w)) begin
            n_bad++; $display("FAIL %s busy_cycles bcd=%h: got %0d required %0d", nm, bcd, bc, e_err ? 0 : w);
        end
        n_cmp++;
        if (bin !== eb) begin
            n_bad++; $display("FAIL %s bin bcd=%h: got %0d required %0d", nm, bcd, bin, eb);
        end
        n_cmp++;
        if (err !== e_err || ovf !== e_ovf) begin
            n_bad++; $display("FAIL %s flags bcd=%h: got err=%b ovf=%b required err=%b ovf=%b",
                              nm, bcd, err, ovf, e_err, e_ovf);
        end
    endtask

    task automatic test_basic;
        check_conv("basic", 1'b0, 16'h0000);
        check_conv("basic", 1'b0, 16'h1234);
        check_conv("basic", 1'b0, 16'h9999);
        for (int i = 0; i < 12; i++) check_conv("basic_rand", 1'b0, rand_valid(4));
    endtask

    task automatic test_invalid;
        logic [15:0] b;
        check_conv("invalid", 1'b0, 16'h12A4);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (err_a !== 1'b1 || done_a !== 1'b0) begin
            n_bad++; $display("FAIL err_hold: got err=%b done=%b required err=1 done=0", err_a, done_a);
        end
        check_conv("after_invalid", 1'b0, 16'h0042);
        for (int i = 0; i < 4; i++) begin
            b = rand_valid(4);
            b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            check_conv("invalid_rand", 1'b0, b);
        end
    endtask

    task automatic test_small;
        check_conv("small", 1'b1, 16'h0300);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ovf_b !== 1'b1 || bin_b !== 8'h2C) begin
            n_bad++; $display("FAIL small_hold: got ovf=%b bin=%h required ovf=1 bin=2c", ovf_b, bin_b);
        end
        check_conv("small", 1'b1, 16'h0255);
        check_conv("small", 1'b1, 16'h0256);
        for (int i = 0; i < 8; i++) check_conv("small_rand", 1'b1, rand_valid(3));
    endtask

    task automatic test_ignore_mid;
        int dones;
        logic [13:0] first;
        dones = 0; first = '0;
        start_a = 1'b1; bcd_a = 16'h1234;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start_a = 1'b1; bcd_a = 16'h0042;
        @(posedge clk); #1;
        start_a = 1'b0; bcd_a = 16'h0777;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done_a) begin
                if (dones == 0) first = bin_a;
                dones++;
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++; $display("FAIL ignore_mid_count: got %0d dones required 1", dones);
        end
        n_cmp++;
        if (first !== 14'd1234) begin
            n_bad++; $display("FAIL ignore_mid_bin: got %0d required 1234", first);
        end
        n_cmp++;
        if (bin_a !== 14'd1234) begin
            n_bad++; $display("FAIL ignore_mid_hold: got %0d required 1234", bin_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        int eb, cnt;
        bit e_err, e_ovf;
        int times[$];
        v = rand_valid(4);
        v[15:12] = 4'($urandom_range(1, 9));
        ref_model(v, 4, 14, eb, e_err, e_ovf);
        start_a = 1'b1; bcd_a = v; cnt = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (done_a) begin
                times.push_back(c);
                n_cmp++;
                if (int'(bin_a) !== eb) begin
                    n_bad++; $display("FAIL b2b_bin: got %0d required %0d", bin_a, eb);
                end
            end
        end
        start_a = 1'b0;
        n_cmp++;
        if (times.size() !== 4) begin
            n_bad++; $display("FAIL b2b_count: got %0d dones required 4", times.size());
        end
        foreach (times[j]) begin
            n_cmp++;
            if (times[j] !== 16 * (j + 1)) begin
                n_bad++; $display("FAIL b2b_spacing: done %0d at cycle %0d required %0d", j, times[j], 16 * (j + 1));
            end
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int dones;
        start_a = 1'b1; bcd_a = 16'h1234;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, bin_a, err_a, ovf_a} !== '0) begin
            n_bad++; $display("FAIL reset_mid_clear: got %b required 0", {busy_a, done_a, bin_a, err_a, ovf_a});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++; $display("FAIL reset_mid_no_done: got %0d active cycles required 0", dones);
        end
        check_conv("after_reset", 1'b0, 16'h0500);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_invalid;
        test_small;
        test_ignore_mid;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
